dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-ported `data_memory`. It shares the memory between the CPU MEM stage and a DMA/loader port. It serialises their load/store requests through a req/gnt/done handshake and drives the memory's `MemR`/`MemW`/address/write-data inputs. It captures read data after a configurable latency and returns it to the requester that owns the access.

## Interface
- `DW`, 32, data width.
- `AW`, 32, address width; passed through unmodified (memory decodes `[9:0]`).
- `MEM_LAT`, 0, extra cycles between strobe and valid `mem_rdata` (0 = combinational memory read).
- `clk  in  1  clock, rising edge`
- `rst_n  in  1  asynchronous, active-low reset`
- `cpu_req  in  1  CPU access request, held until cpu_gnt`
- `cpu_we  in  1  1 = store, 0 = load`
- `cpu_addr  in  AW  CPU address`
- `cpu_wdata  in  DW  CPU store data`
- `cpu_gnt  out  1  one-cycle grant pulse`
- `cpu_done  out  1  one-cycle completion pulse`
- `cpu_rdata  out  DW  load data, valid when cpu_done && load`
- `dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata`: identical set for DMA port.
- `mem_r  out  1  to data_memory MemR`
- `mem_w  out  1  to data_memory MemW`
- `mem_addr  out  AW  to data_memory address`
- `mem_wdata  out  DW  to data_memory writeData`
- `mem_rdata  in  DW  from data_memory readData`

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any req, pick winner, latch `we`/`addr`/`wdata` and owner id, go ACCESS. No req: stay.
- ACCESS (1 cycle): owner `gnt`=1; `mem_addr`/`mem_wdata` drive latched values; `mem_w`=we, `mem_r`=!we. Store: go RESP. Load: go WAIT if `MEM_LAT`>0, else sample `mem_rdata` at end of cycle and go RESP.
- WAIT: `mem_r` held high, `mem_addr` held; down-counter loaded with `MEM_LAT`, sample `mem_rdata` on the edge where counter reaches 1, go RESP.
- RESP (1 cycle): owner `done`=1; owner `rdata` = captured data (held until next load by that owner); all mem strobes 0; go IDLE.
- Arbitration without macro: fixed priority, CPU beats DMA.
- Requester rules: `req`/`we`/`addr`/`wdata` stable until `gnt`; `req` still high in the cycle after `gnt` is a new request.
- Non-owner `gnt`/`done` stay 0. A losing requester keeps waiting with no timeout.
- `mem_addr`/`mem_wdata` hold the last latched values outside ACCESS/WAIT. Strobes are never both 1.

## Timing
- Request first seen in IDLE at cycle T: `gnt` and strobe in T+1. Store `done` in T+2. Load `done` in T+2+`MEM_LAT`.
- Next acceptance earliest in cycle after RESP. Throughput: one access per 3 (store) or 3+`MEM_LAT` (load) cycles.
- All outputs registered.
- Reset (async assert, sync deassert by caller): state IDLE, all `gnt`/`done`/`mem_r`/`mem_w` 0, `rdata`s 0, `mem_addr`/`mem_wdata` 0, RR pointer → CPU-first, counter 0.
- Reset mid-access drops the transaction: no `done`, and a store may or may not have reached memory.

## Configuration
- `DMEM_ARB_RR_EN` defined: two-way round-robin. On simultaneous requests the port not granted last wins. The pointer updates on every grant; after reset CPU wins the first tie. Single requester always wins immediately.
- Not defined: fixed priority CPU > DMA; no pointer register.

## Structure
- Package `dmem_arb_pkg`: FSM state enum, owner id constants (`OWN_CPU`=0, `OWN_DMA`=1), default `DW`/`AW`.
- Sub-module `rr_arb2`: 2-input arbiter (req vector in, one-hot grant out, `advance` input updates pointer). It implements fixed or RR per macro, and the top owns the FSM, latches and counter.

## Test plan
- CPU store addr 0x4, data 0xDEAD_BEEF, `MEM_LAT`=0 → `cpu_gnt`+`mem_w` at T+1 with `mem_addr`=4, `cpu_done` at T+2; memory word 4 = 0xDEAD_BEEF.
- CPU load addr 0x4 after above, `MEM_LAT`=2 → `mem_r` high T+1..T+3, `cpu_done` T+4, `cpu_rdata`=0xDEAD_BEEF.
- CPU and DMA req same cycle, no macro, repeated 3 times → CPU granted each time. DMA is granted only once CPU drops `req`.
- Same with `DMEM_ARB_RR_EN` → grants alternate CPU, DMA, CPU, DMA, and each `done` goes only to the granted port.
- DMA load in WAIT, `rst_n` pulsed low → all outputs 0 immediately, no `dma_done`, next CPU request after release granted at T+1.
- Back-to-back CPU stores to 0..3 with `req` held → one grant every 3 cycles, 4 `done` pulses, `mem_r` never asserted.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 32;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes plus the data_memory side.
// slave = arbiter view, master = requesters/memory view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();
  logic          cpu_req, cpu_we, cpu_gnt, cpu_done;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_gnt, dma_done;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_r, mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_done, dma_rdata,
    output mem_r, mem_w, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_r, mem_w, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input arbiter. DMEM_ARB_RR_EN defined: round-robin (port not granted
// last wins a tie, CPU first after reset). Undefined: fixed CPU > DMA.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);
`ifdef DMEM_ARB_RR_EN
  logic r_prio;  // 1 = DMA wins a tie

  // Tie broken by pointer, single requester passes straight through
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = r_prio ? 2'b10 : 2'b01;
  end

  // Pointer flips to the other port on every accepted grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_prio <= 1'b0;
    else if (i_advance) r_prio <= o_gnt[0];
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst_n, i_advance};
  assign o_gnt    = {i_req[1] & ~i_req[0], i_req[0]};
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU and DMA accesses onto the single-ported data memory.
// Arbitration policy selected by DMEM_ARB_RR_EN (see rr_arb2).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int MEM_LAT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  localparam int            CW       = $clog2(MEM_LAT + 2);
  localparam logic [CW-1:0] LAT_LD   = CW'(MEM_LAT);
  localparam bit            HAS_WAIT = (MEM_LAT > 0);

  state_e        r_state, w_nxt;
  logic          r_own, r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_gnt, r_done;
  logic          r_mem_r, r_mem_w;
  logic [DW-1:0] r_cpu_rdata, r_dma_rdata;

  logic [1:0]    w_req, w_gnt_oh;
  logic          w_accept, w_win, w_win_we, w_cnt_one, w_cap, w_fin;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;

  assign w_req       = {bus.dma_req, bus.cpu_req};
  assign w_accept    = (r_state == IDLE) && (|w_req);
  assign w_win       = w_gnt_oh[1];
  assign w_win_we    = w_win ? bus.dma_we    : bus.cpu_we;
  assign w_win_addr  = w_win ? bus.dma_addr  : bus.cpu_addr;
  assign w_win_wdata = w_win ? bus.dma_wdata : bus.cpu_wdata;
  assign w_cnt_one   = (r_cnt == CW'(1));
  // Read data is valid at the end of ACCESS for a combinational memory,
  // otherwise on the last WAIT cycle.
  assign w_cap = ((r_state == ACCESS) && !r_we && !HAS_WAIT) ||
                 ((r_state == WAIT) && w_cnt_one);
  assign w_fin = (r_state != RESP) && (w_nxt == RESP);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_req),
    .i_advance (w_accept),
    .o_gnt     (w_gnt_oh)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state decode
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_req) w_nxt = ACCESS;
      ACCESS:  w_nxt = (r_we || !HAS_WAIT) ? RESP : WAIT;
      WAIT:    if (w_cnt_one) w_nxt = RESP;
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Latches, latency counter and registered outputs (one cycle ahead of state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own       <= OWN_CPU;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_mem_r     <= 1'b0;
      r_mem_w     <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_own   <= w_win;
        r_we    <= w_win_we;
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
      end
      r_gnt   <= w_accept ? w_gnt_oh : 2'b00;
      r_mem_w <= w_accept && w_win_we;
      r_mem_r <= (w_accept && !w_win_we) ||
                 ((r_state == ACCESS) && !r_we && HAS_WAIT) ||
                 ((r_state == WAIT) && !w_cnt_one);
      r_done  <= w_fin ? ((r_own == OWN_DMA) ? 2'b10 : 2'b01) : 2'b00;

      if ((r_state == ACCESS) && !r_we) r_cnt <= LAT_LD;
      else if (r_state == WAIT)         r_cnt <= r_cnt - 1'b1;

      if (w_cap) begin
        if (r_own == OWN_DMA) r_dma_rdata <= bus.mem_rdata;
        else                  r_cpu_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.cpu_gnt   = r_gnt[0];
  assign bus.dma_gnt   = r_gnt[1];
  assign bus.cpu_done  = r_done[0];
  assign bus.dma_done  = r_done[1];
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.mem_r     = r_mem_r;
  assign bus.mem_w     = r_mem_w;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a latency-2 memory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DW(32), .AW(32)) bus ();

  dmem_arbiter #(.DW(32), .AW(32), .MEM_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: read data only becomes valid after LAT cycles of mem_r
  logic [31:0] mem [0:1023];
  int rcnt = 0;
  always @(posedge clk) begin
    if (bus.mem_w) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    rcnt <= bus.mem_r ? rcnt + 1 : 0;
  end
  assign bus.mem_rdata = (bus.mem_r && rcnt >= LAT) ? mem[bus.mem_addr[9:0]] : 32'hBAD0_BAD0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          done;
    bit          port;
    int          cyc;
    bit          load;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;
  int  n_both = 0, n_memr = 0;
  bit  no_memr = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void expect_ev(bit d, bit p, int c, bit ld, logic [31:0] v);
    ev_t e;
    e.done = d; e.port = p; e.cyc = c; e.load = ld; e.data = v;
    exp_q.push_back(e);
  endfunction

  // Monitor: every gnt/done pulse pops and checks the next expected event
  logic [3:0] fired;
  ev_t        me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_r && bus.mem_w) n_both++;
      if (no_memr && bus.mem_r)   n_memr++;
      fired = {bus.dma_done, bus.cpu_done, bus.dma_gnt, bus.cpu_gnt};
      for (int k = 0; k < 4; k++) begin
        if (fired[k]) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, none pending", k, cyc);
          end else begin
            me = exp_q.pop_front();
            chk("event_kind", 64'(k), 64'({me.done, me.port}));
            chk("event_cycle", 64'(cyc), 64'(me.cyc));
            if (me.done && me.load)
              chk("load_rdata", me.port ? bus.dma_rdata : bus.cpu_rdata, me.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit p, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  task automatic drop(input bit p);
    if (p) bus.dma_req = 1'b0;
    else   bus.cpu_req = 1'b0;
  endtask

  // n stores from one port with req held; next addr/data presented after each gnt
  task automatic run_port(input bit p, input int n, input logic [31:0] a0, input logic [31:0] d0);
    drive(p, 1'b1, 1'b1, a0, d0);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!(p ? bus.dma_gnt : bus.cpu_gnt) && w < 60) begin
        @(negedge clk); w++;
      end
      if (w >= 60) begin
        n_cmp++; n_bad++;
        $display("FAIL gnt_timeout: port %0d got no grant, want grant %0d", p, i);
        drop(p);
        return;
      end
      tick();
      if (i == n - 1) drop(p);
      else            drive(p, 1'b1, 1'b1, a0 + 32'(i + 1), d0 + 32'(i + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  int c;
  bit tie_port [5];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) tick();

    // Reset state
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_dma_gnt", bus.dma_gnt, 0);
    chk("rst_done", {bus.cpu_done, bus.dma_done}, 0);
    chk("rst_strobes", {bus.mem_r, bus.mem_w}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
    rst_n = 1'b1;
    tick();

    // Simultaneous requests: CPU 3 stores, DMA 2 stores
`ifdef DMEM_ARB_RR_EN
    tie_port = '{0, 1, 0, 1, 0};
`else
    tie_port = '{0, 0, 0, 1, 1};
`endif
    c = cyc;
    for (int i = 0; i < 5; i++) begin
      expect_ev(0, tie_port[i], c + 1 + 3 * i, 0, 0);
      expect_ev(1, tie_port[i], c + 2 + 3 * i, 0, 0);
    end
    fork
      run_port(0, 3, 32'h10, 32'hC000_0000);
      run_port(1, 2, 32'h20, 32'hD000_0000);
    join
    repeat (2) tick();
    chk("tie_mem10", mem[10'h10], 32'hC000_0000);
    chk("tie_mem11", mem[10'h11], 32'hC000_0001);
    chk("tie_mem12", mem[10'h12], 32'hC000_0002);
    chk("tie_mem20", mem[10'h20], 32'hD000_0000);
    chk("tie_mem21", mem[10'h21], 32'hD000_0001);

    // CPU store 0xDEADBEEF to address 4
    c = cyc;
    drive(0, 1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF);
    expect_ev(0, 0, c + 1, 0, 0);
    expect_ev(1, 0, c + 2, 0, 0);
    tick();
    chk("st_mem_w", bus.mem_w, 1);
    chk("st_mem_r", bus.mem_r, 0);
    chk("st_mem_addr", bus.mem_addr, 32'h4);
    chk("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    drop(0);
    repeat (2) tick();
    chk("st_mem4", mem[4], 32'hDEAD_BEEF);

    // CPU load from address 4: mem_r high for LAT+1 cycles
    c = cyc;
    drive(0, 1'b1, 1'b0, 32'h4, 32'h0);
    expect_ev(0, 0, c + 1, 0, 0);
    expect_ev(1, 0, c + 4, 1, 32'hDEAD_BEEF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) drop(0);
      chk("ld_mem_r", bus.mem_r, (k < 4) ? 1 : 0);
    end
    repeat (3) tick();
    chk("ld_rdata_hold", bus.cpu_rdata, 32'hDEAD_BEEF);

    // DMA load aborted by reset while in WAIT
    c = cyc;
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
    expect_ev(0, 1, c + 1, 0, 0);
    tick();
    drop(1);
    tick();
    chk("abort_pre_mem_r", bus.mem_r, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {bus.mem_r, bus.mem_w}, 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk("abort_mem_wdata", bus.mem_wdata, 0);
    chk("abort_rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
    chk("abort_gnt_done", {bus.cpu_gnt, bus.dma_gnt, bus.cpu_done, bus.dma_done}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // First CPU load after reset release
    c = cyc;
    drive(0, 1'b1, 1'b0, 32'h11, 32'h0);
    expect_ev(0, 0, c + 1, 0, 0);
    expect_ev(1, 0, c + 4, 1, 32'hC000_0001);
    tick();
    drop(0);
    repeat (4) tick();

    // Back-to-back CPU stores to 0..3 with req held
    no_memr = 1'b1;
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      expect_ev(0, 0, c + 1 + 3 * i, 0, 0);
      expect_ev(1, 0, c + 2 + 3 * i, 0, 0);
    end
    run_port(0, 4, 32'h0, 32'hA000_0000);
    repeat (2) tick();
    no_memr = 1'b0;
    chk("b2b_mem_r_cycles", n_memr, 0);
    for (int i = 0; i < 4; i++) chk("b2b_mem", mem[i], 32'hA000_0000 + 32'(i));

    repeat (3) tick();
    chk("pending_events", exp_q.size(), 0);
    chk("strobe_overlap", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
